// File: rtl/fifo_wptr_full.sv
// Async FIFO write side: binary/Gray write pointer, read-pointer synchroniser, full and overflow flags.
// Optional build macro FIFO_WLEVEL_EN adds the registered w_level / almost_full outputs.
module fifo_wptr_full #(
    parameter int ADDR_WIDTH  = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 6
) (
    input  logic                  w_clk,
    input  logic                  wrst,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  w_inc,
    output logic                  fifo_full,
    output logic                  w_overflow
`ifdef FIFO_WLEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   w_level,
    output logic                  almost_full
`endif
);

    localparam int PW = ADDR_WIDTH + 1;

    if (SYNC_STAGES < 2 || AF_THRESH < 1 || AF_THRESH > (1 << ADDR_WIDTH)) begin : g_bad_param
        $error("fifo_wptr_full: illegal SYNC_STAGES or AF_THRESH");
    end

    logic [SYNC_STAGES-1:0][PW-1:0] rq_pipe;
    logic [PW-1:0]                  rq_sync;
    logic [PW-1:0]                  wbin_nxt;
    logic [PW-1:0]                  wgray_nxt;
    logic [PW-1:0]                  full_tgt;

    // Plain flop chain: the Gray code guarantees at most one bit in flight.
    always_ff @(posedge w_clk) begin
        if (!wrst) rq_pipe <= '0;
        else       rq_pipe <= {rq_pipe[SYNC_STAGES-2:0], rptr_gray};
    end

    assign rq_sync   = rq_pipe[SYNC_STAGES-1];
    assign w_inc     = w_en & ~fifo_full;
    assign waddr     = wptr[ADDR_WIDTH-1:0];
    assign wbin_nxt  = wptr + {{ADDR_WIDTH{1'b0}}, w_inc};
    assign wgray_nxt = wbin_nxt ^ (wbin_nxt >> 1);
    // Full when write is one lap ahead: top two Gray bits inverted, rest equal.
    assign full_tgt  = {~rq_sync[ADDR_WIDTH:ADDR_WIDTH-1], rq_sync[ADDR_WIDTH-2:0]};

    always_ff @(posedge w_clk) begin
        if (!wrst) begin
            wptr       <= '0;
            wptr_gray  <= '0;
            fifo_full  <= 1'b0;
            w_overflow <= 1'b0;
        end else begin
            wptr      <= wbin_nxt;
            wptr_gray <= wgray_nxt;
            fifo_full <= (wgray_nxt == full_tgt);
            if (w_en && fifo_full) w_overflow <= 1'b1;
        end
    end

`ifdef FIFO_WLEVEL_EN
    logic [PW-1:0] rbin;
    logic [PW-1:0] wlvl_nxt;

    always_comb begin
        rbin = '0;
        for (int i = 0; i < PW; i++) rbin[i] = ^(rq_sync >> i);
    end

    assign wlvl_nxt = wbin_nxt - rbin;

    always_ff @(posedge w_clk) begin
        if (!wrst) begin
            w_level     <= '0;
            almost_full <= 1'b0;
        end else begin
            w_level     <= wlvl_nxt;
            almost_full <= (wlvl_nxt >= PW'(AF_THRESH));
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed-vector bench for fifo_wptr_full at default parameters (depth 8, 2 sync stages).
// Level/almost-full checks are built only when FIFO_WLEVEL_EN is defined.
module tb_fifo_wptr_full;

    logic       w_clk = 1'b0;
    logic       wrst = 1'b0;
    logic       w_en = 1'b0;
    logic [3:0] rptr_gray = 4'd0;
    logic [3:0] wptr;
    logic [2:0] waddr;
    logic [3:0] wptr_gray;
    logic       w_inc;
    logic       fifo_full;
    logic       w_overflow;
`ifdef FIFO_WLEVEL_EN
    logic [3:0] w_level;
    logic       almost_full;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 w_clk = ~w_clk;

    fifo_wptr_full #(.ADDR_WIDTH(3), .SYNC_STAGES(2), .AF_THRESH(6)) dut (
        .w_clk(w_clk), .wrst(wrst), .w_en(w_en), .rptr_gray(rptr_gray),
        .wptr(wptr), .waddr(waddr), .wptr_gray(wptr_gray), .w_inc(w_inc),
        .fifo_full(fifo_full), .w_overflow(w_overflow)
`ifdef FIFO_WLEVEL_EN
        , .w_level(w_level), .almost_full(almost_full)
`endif
    );

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [3:0] rg;
        logic       chk_inc;
        logic       exp_inc;
        logic [3:0] exp_wptr;
        logic [3:0] exp_gray;
        logic       exp_full;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic r, logic e, logic [3:0] g, logic ci, logic ei,
                                logic [3:0] ew, logic [3:0] eg, logic ef, logic eo);
        vec_t v;
        v.rst_n = r; v.en = e; v.rg = g; v.chk_inc = ci; v.exp_inc = ei;
        v.exp_wptr = ew; v.exp_gray = eg; v.exp_full = ef; v.exp_ovf = eo;
        tbl.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive at negedge, check comb w_inc before the edge, registered outputs after it.
    task automatic step(input vec_t v, input string tag);
        @(negedge w_clk);
        wrst = v.rst_n; w_en = v.en; rptr_gray = v.rg;
        #1;
        if (v.chk_inc) chk({tag, ".w_inc"}, 32'(w_inc), 32'(v.exp_inc));
        @(posedge w_clk);
        #1;
        chk({tag, ".wptr"},       32'(wptr),       32'(v.exp_wptr));
        chk({tag, ".waddr"},      32'(waddr),      32'(v.exp_wptr[2:0]));
        chk({tag, ".wptr_gray"},  32'(wptr_gray),  32'(v.exp_gray));
        chk({tag, ".fifo_full"},  32'(fifo_full),  32'(v.exp_full));
        chk({tag, ".w_overflow"}, 32'(w_overflow), 32'(v.exp_ovf));
    endtask

    initial begin
        vec_t v;
        logic [3:0] gh[$];
        logic [3:0] eb;

        // Reset held 4 edges with w_en high
        for (int i = 0; i < 4; i++) add(0, 1, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0);
        // Fill 8 words, read side parked at 0
        add(1, 1, 4'h0, 1, 1, 4'h1, 4'h1, 0, 0);
        add(1, 1, 4'h0, 1, 1, 4'h2, 4'h3, 0, 0);
        add(1, 1, 4'h0, 1, 1, 4'h3, 4'h2, 0, 0);
        add(1, 1, 4'h0, 1, 1, 4'h4, 4'h6, 0, 0);
        add(1, 1, 4'h0, 1, 1, 4'h5, 4'h7, 0, 0);
        add(1, 1, 4'h0, 1, 1, 4'h6, 4'h5, 0, 0);
        add(1, 1, 4'h0, 1, 1, 4'h7, 4'h4, 0, 0);
        add(1, 1, 4'h0, 1, 1, 4'h8, 4'hC, 1, 0);
        // Write while full: dropped, overflow sticks
        add(1, 1, 4'h0, 1, 0, 4'h8, 4'hC, 1, 1);
        // Read pointer moves to 1: full clears after the third edge
        add(1, 0, 4'h1, 1, 0, 4'h8, 4'hC, 1, 1);
        add(1, 0, 4'h1, 1, 0, 4'h8, 4'hC, 1, 1);
        add(1, 0, 4'h1, 1, 0, 4'h8, 4'hC, 0, 1);
        // One more write refills
        add(1, 1, 4'h1, 1, 1, 4'h9, 4'hD, 1, 1);
        // Reset from full, then 5 writes, then reset mid-operation
        add(0, 1, 4'h0, 1, 0, 4'h0, 4'h0, 0, 0);
        add(1, 1, 4'h0, 1, 1, 4'h1, 4'h1, 0, 0);
        add(1, 1, 4'h0, 1, 1, 4'h2, 4'h3, 0, 0);
        add(1, 1, 4'h0, 1, 1, 4'h3, 4'h2, 0, 0);
        add(1, 1, 4'h0, 1, 1, 4'h4, 4'h6, 0, 0);
        add(1, 1, 4'h0, 1, 1, 4'h5, 4'h7, 0, 0);
        add(0, 1, 4'h0, 1, 1, 4'h0, 4'h0, 0, 0);
        add(1, 1, 4'h0, 1, 1, 4'h1, 4'h1, 0, 0);
        add(1, 1, 4'h0, 1, 1, 4'h2, 4'h3, 0, 0);
        add(1, 0, 4'h0, 1, 0, 4'h2, 4'h3, 0, 0);

        foreach (tbl[i]) step(tbl[i], $sformatf("v%0d", i));

        // Wrap: 20 writes, read pointer trails the model's Gray pointer by 2 cycles
        v.rst_n = 0; v.en = 0; v.rg = 4'h0; v.chk_inc = 0; v.exp_inc = 0;
        v.exp_wptr = 4'h0; v.exp_gray = 4'h0; v.exp_full = 0; v.exp_ovf = 0;
        step(v, "wrap_rst");
        gh = '{4'h0, 4'h0, 4'h0};
        eb = 4'h0;
        for (int k = 1; k <= 20; k++) begin
            eb = eb + 4'd1;
            v.rst_n = 1; v.en = 1; v.rg = gh[gh.size()-3];
            v.chk_inc = 1; v.exp_inc = 1;
            v.exp_wptr = eb; v.exp_gray = eb ^ (eb >> 1);
            v.exp_full = 0; v.exp_ovf = 0;
            step(v, $sformatf("wrap%0d", k));
            gh.push_back(v.exp_gray);
        end

`ifdef FIFO_WLEVEL_EN
        // Level: 6 writes -> level 6, almost_full; read to 2 -> level 4 after 3 edges
        v.rst_n = 0; v.en = 0; v.rg = 4'h0; v.chk_inc = 0; v.exp_inc = 0;
        v.exp_wptr = 4'h0; v.exp_gray = 4'h0; v.exp_full = 0; v.exp_ovf = 0;
        step(v, "lvl_rst");
        chk("lvl_rst.w_level", 32'(w_level), 32'd0);
        chk("lvl_rst.almost_full", 32'(almost_full), 32'd0);
        eb = 4'h0;
        for (int k = 1; k <= 6; k++) begin
            eb = eb + 4'd1;
            v.rst_n = 1; v.en = 1; v.rg = 4'h0; v.chk_inc = 1; v.exp_inc = 1;
            v.exp_wptr = eb; v.exp_gray = eb ^ (eb >> 1);
            step(v, $sformatf("lvl_w%0d", k));
        end
        chk("lvl6.w_level", 32'(w_level), 32'd6);
        chk("lvl6.almost_full", 32'(almost_full), 32'd1);
        v.en = 0; v.rg = 4'h3; v.exp_inc = 0;
        step(v, "lvl_r1");
        step(v, "lvl_r2");
        chk("lvl_r2.w_level", 32'(w_level), 32'd6);
        step(v, "lvl_r3");
        chk("lvl4.w_level", 32'(w_level), 32'd4);
        chk("lvl4.almost_full", 32'(almost_full), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
